// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the unified memory arbiter
//               and the RAM model it drives.
//               state_t    - arbiter FSM states
//               OWN_*      - owner encodings (fetch / data port)
//               DEF_AW     - default RAM word-address width
//               DEF_LAT    - default RAM read latency (cycles)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    localparam int DEF_AW  = 6;
    localparam int DEF_LAT = 1;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_lat_counter.sv
`default_nettype none
// ============================================================================
// Module      : mem_lat_counter
// Description : Down-counter timing the RAM read latency. Loaded while the
//               arbiter issues an access, decremented while it waits; the
//               zero flag marks the cycle in which RAM read data is valid.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               i_load     - load i_load_val (has priority over i_dec)
//               i_load_val - value to load
//               i_dec      - decrement (saturates at zero)
//               o_zero     - counter equals zero
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lat_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule : mem_lat_counter
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_arbiter
// Description : Shares one fixed-latency, single-ported RAM between the
//               core's fetch (IF) and memory (MEM) stages. Each access runs
//               IDLE -> ISSUE -> WAIT -> DONE; DONE hands the RAM straight to
//               the other port when it is requesting, so the ports alternate.
//               Data wins over fetch when both request in IDLE.
// Ports       : clk, reset              - clock / async active-low reset
//               if_req/if_addr          - fetch request and byte address
//               if_ack/if_rdata         - fetch completion pulse and data
//               mem_req/mem_we/mem_addr/mem_wdata - data request
//               mem_ack/mem_rdata       - data completion pulse and load data
//               ram_en/ram_we/ram_addr/ram_wdata/ram_rdata - RAM port
//               stall_if/stall_mem      - hold pipeline while outstanding
//               busy                    - FSM not idle
// Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = DEF_AW,
    parameter int LAT  = DEF_LAT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_ack,
    output logic [XLEN-1:0] if_rdata,
    input  logic            mem_req,
    input  logic            mem_we,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_wdata,
    output logic            mem_ack,
    output logic [XLEN-1:0] mem_rdata,
    output logic            ram_en,
    output logic            ram_we,
    output logic [AW-1:0]   ram_addr,
    output logic [XLEN-1:0] ram_wdata,
    input  logic [XLEN-1:0] ram_rdata,
    output logic            stall_if,
    output logic            stall_mem,
    output logic            busy
);

    localparam int            CW     = $clog2(LAT + 1);
    localparam logic [CW-1:0] C_LOAD = CW'(LAT - 1);

    state_t          r_state;
    logic            r_owner;
    logic            r_we;
    logic            r_ram_en;
    logic            r_ram_we;
    logic [AW-1:0]   r_ram_addr;
    logic [XLEN-1:0] r_ram_wdata;
    logic            r_if_ack;
    logic            r_mem_ack;
    logic [XLEN-1:0] r_if_rdata;
    logic [XLEN-1:0] r_mem_rdata;

    logic            w_grant_valid;
    logic            w_grant_owner;
    logic [XLEN-1:0] w_grant_addr;
    logic            w_grant_we;
    logic            w_cnt_zero;
    logic            w_unused_addr;

    // Byte-offset and high address bits play no part in the word address.
    assign w_unused_addr = ^{if_addr, mem_addr};

    // Who gets the RAM next. In DONE only the non-owner is considered: the
    // owner's req is still high during its own ack cycle and must not be
    // mistaken for a new request.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_owner = OWN_FETCH;
        if (r_state == IDLE) begin
            if (mem_req) begin
                w_grant_valid = 1'b1;
                w_grant_owner = OWN_DATA;
            end else if (if_req) begin
                w_grant_valid = 1'b1;
                w_grant_owner = OWN_FETCH;
            end
        end else if (r_state == DONE) begin
            if (r_owner == OWN_FETCH) begin
                w_grant_valid = mem_req;
                w_grant_owner = OWN_DATA;
            end else begin
                w_grant_valid = if_req;
                w_grant_owner = OWN_FETCH;
            end
        end
    end

    assign w_grant_addr = (w_grant_owner == OWN_DATA) ? mem_addr : if_addr;
    assign w_grant_we   = (w_grant_owner == OWN_DATA) && mem_we;

    mem_lat_counter #(
        .WIDTH (CW)
    ) u_lat_cnt (
        .clk        (clk),
        .rst_n      (reset),
        .i_load     (r_state == ISSUE),
        .i_load_val (C_LOAD),
        .i_dec      (r_state == WAIT),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_owner     <= OWN_FETCH;
            r_we        <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_mem_ack   <= 1'b0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else begin
            // Strobes and acks are single-cycle unless re-asserted below.
            r_ram_en  <= 1'b0;
            r_ram_we  <= 1'b0;
            r_if_ack  <= 1'b0;
            r_mem_ack <= 1'b0;
            unique case (r_state)
                IDLE, DONE: begin
                    if (w_grant_valid) begin
                        r_owner    <= w_grant_owner;
                        r_we       <= w_grant_we;
                        r_ram_addr <= w_grant_addr[AW+1:2];
                        if (w_grant_owner == OWN_DATA) begin
                            r_ram_wdata <= mem_wdata;
                        end
                        // Strobes are set here so they are high exactly in ISSUE.
                        r_ram_en   <= 1'b1;
                        r_ram_we   <= w_grant_we;
                        r_state    <= ISSUE;
                    end else begin
                        r_state    <= IDLE;
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (w_cnt_zero) begin
                        if (r_owner == OWN_DATA) begin
                            if (!r_we) begin
                                r_mem_rdata <= ram_rdata;
                            end
                            r_mem_ack <= 1'b1;
                        end else begin
                            r_if_rdata <= ram_rdata;
                            r_if_ack   <= 1'b1;
                        end
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign if_ack    = r_if_ack;
    assign mem_ack   = r_mem_ack;
    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;
    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign stall_if  = if_req & ~r_if_ack;
    assign stall_mem = mem_req & ~r_mem_ack;
    assign busy      = (r_state != IDLE);

endmodule : unified_mem_arbiter
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_unified_mem_arbiter
// Description : Directed bench for unified_mem_arbiter. Four arbiters with
//               LAT = 1..4 share one stimulus; each scenario checks the
//               instance with the latency it targets. Each instance has its
//               own RAM model that returns a poison word outside the valid
//               read-data cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

    localparam int          NDUT   = 4;
    localparam int          AW     = 6;
    localparam logic [31:0] POISON = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic        preload;

    logic          if_ack_a    [NDUT];
    logic          mem_ack_a   [NDUT];
    logic          ram_en_a    [NDUT];
    logic          ram_we_a    [NDUT];
    logic          stall_if_a  [NDUT];
    logic          stall_mem_a [NDUT];
    logic          busy_a      [NDUT];
    logic [31:0]   if_rdata_a  [NDUT];
    logic [31:0]   mem_rdata_a [NDUT];
    logic [31:0]   ram_wdata_a [NDUT];
    logic [31:0]   ram_rdata_a [NDUT];
    logic [AW-1:0] ram_addr_a  [NDUT];

    logic [31:0] ram  [NDUT][64];
    logic [31:0] pipe [NDUT][4];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc, nwe, n_acks, last_ack;
    logic expect_data;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        unified_mem_arbiter #(
            .XLEN (32),
            .AW   (AW),
            .LAT  (k + 1)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_ack    (if_ack_a[k]),
            .if_rdata  (if_rdata_a[k]),
            .mem_req   (mem_req),
            .mem_we    (mem_we),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_ack   (mem_ack_a[k]),
            .mem_rdata (mem_rdata_a[k]),
            .ram_en    (ram_en_a[k]),
            .ram_we    (ram_we_a[k]),
            .ram_addr  (ram_addr_a[k]),
            .ram_wdata (ram_wdata_a[k]),
            .ram_rdata (ram_rdata_a[k]),
            .stall_if  (stall_if_a[k]),
            .stall_mem (stall_mem_a[k]),
            .busy      (busy_a[k])
        );
        // Instance k has LAT = k+1, so its data leaves pipe stage k.
        assign ram_rdata_a[k] = pipe[k][k];
    end

    function automatic logic [31:0] init_word(input int w);
        case (w)
            3:       return 32'h00A0_0093;
            4:       return 32'h1111_1111;
            5:       return 32'hCAFE_F00D;
            16:      return 32'h2222_2222;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // RAM models: write on a write strobe, read data valid only LAT cycles
    // after a read strobe, poison otherwise.
    always @(posedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (preload) begin
                for (int w = 0; w < 64; w++) ram[k][w] <= init_word(w);
            end else if (ram_en_a[k] && ram_we_a[k]) begin
                ram[k][ram_addr_a[k]] <= ram_wdata_a[k];
            end
            pipe[k][0] <= (ram_en_a[k] && !ram_we_a[k]) ? ram[k][ram_addr_a[k]] : POISON;
            for (int j = 1; j < 4; j++) pipe[k][j] <= pipe[k][j-1];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        if_req  = 1'b0;
        mem_req = 1'b0;
        reset   = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Raise one request in the current cycle (cycle 0) and wait for its ack.
    // cyc = cycles from request to ack (-1 on timeout), nwe = write strobes seen.
    task automatic access(input int k, input bit is_data, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int cyc_o, output int nwe_o);
        cyc_o = -1;
        nwe_o = 0;
        if (is_data) begin
            mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ram_en_a[k] && ram_we_a[k]) nwe_o++;
            if ((is_data ? mem_ack_a[k] : if_ack_a[k]) == 1'b1) begin
                cyc_o = i;
                break;
            end
        end
        mem_req = 1'b0;
        if_req  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        preload   = 1'b1;
        reset     = 1'b0;
        if_req    = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b0;
        if_addr   = 32'h0000_000C;
        mem_addr  = 32'h0000_0040;
        mem_wdata = 32'h0;
        tick();
        preload = 1'b0;

        // ---- Reset held with both requests high ----
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_ram_en", {28'd0, ram_en_a[0], ram_en_a[1], ram_en_a[2], ram_en_a[3]}, 32'd0);
        end
        check("rst_if_ack",    if_ack_a[0],    32'd0);
        check("rst_mem_ack",   mem_ack_a[0],   32'd0);
        check("rst_if_rdata",  if_rdata_a[0],  32'd0);
        check("rst_mem_rdata", mem_rdata_a[0], 32'd0);
        check("rst_ram_we",    ram_we_a[0],    32'd0);
        check("rst_ram_addr",  ram_addr_a[0],  32'd0);
        check("rst_ram_wdata", ram_wdata_a[0], 32'd0);
        check("rst_busy",      busy_a[0],      32'd0);
        check("rst_stall_if",  stall_if_a[0],  32'd1);
        check("rst_stall_mem", stall_mem_a[0], 32'd1);

        // ---- Single fetch, LAT=1 ----
        reset_pulse();
        if_req = 1'b1; if_addr = 32'h0000_000C;           // cycle 0
        tick();                                           // cycle 1
        check("f1_ram_en",   ram_en_a[0],   32'd1);
        check("f1_ram_addr", ram_addr_a[0], 32'd3);
        check("f1_ram_we",   ram_we_a[0],   32'd0);
        check("f1_stall_if", stall_if_a[0], 32'd1);
        tick();                                           // cycle 2
        check("f1_ack_c2",   if_ack_a[0],   32'd0);
        tick();                                           // cycle 3
        check("f1_ack_c3",   if_ack_a[0],   32'd1);
        check("f1_rdata",    if_rdata_a[0], 32'h00A0_0093);
        check("f1_stall_c3", stall_if_a[0], 32'd0);
        if_req = 1'b0;
        tick();                                           // cycle 4
        check("f1_busy_c4",  busy_a[0],     32'd0);
        check("f1_ack_c4",   if_ack_a[0],   32'd0);

        // ---- Simultaneous fetch and load, LAT=1; data wins ----
        reset_pulse();
        if_req  = 1'b1; if_addr  = 32'h0000_0010;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h1000_0043;  // word 16
        tick();                                           // cycle 1
        check("sim_issue1_en",   ram_en_a[0],   32'd1);
        check("sim_issue1_addr", ram_addr_a[0], 32'd16);
        tick();
        tick();                                           // cycle 3
        check("sim_mem_ack3",  mem_ack_a[0],   32'd1);
        check("sim_if_ack3",   if_ack_a[0],    32'd0);
        check("sim_mem_rdata", mem_rdata_a[0], 32'h2222_2222);
        check("sim_stall_if3", stall_if_a[0],  32'd1);
        mem_req = 1'b0;
        tick();                                           // cycle 4
        check("sim_issue2_en",   ram_en_a[0],   32'd1);
        check("sim_issue2_addr", ram_addr_a[0], 32'd4);
        tick();
        tick();                                           // cycle 6
        check("sim_if_ack6",  if_ack_a[0],   32'd1);
        check("sim_mem_ack6", mem_ack_a[0],  32'd0);
        check("sim_if_rdata", if_rdata_a[0], 32'h1111_1111);
        if_req = 1'b0;

        // ---- Store then load, LAT=3 ----
        reset_pulse();
        access(2, 1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, cyc, nwe);
        check("st_latency",   cyc,            32'd5);
        check("st_we_pulses", nwe,            32'd1);
        check("st_rdata",     mem_rdata_a[2], 32'd0);
        check("st_ram_word",  ram[2][8],      32'hDEAD_BEEF);
        tick();
        access(2, 1'b1, 1'b0, 32'h0000_0020, 32'h0, cyc, nwe);
        check("ld_latency",   cyc,            32'd5);
        check("ld_we_pulses", nwe,            32'd0);
        check("ld_rdata",     mem_rdata_a[2], 32'hDEAD_BEEF);

        // ---- Reset during WAIT of a fetch, LAT=4 ----
        reset_pulse();
        if_req = 1'b1; if_addr = 32'h0000_000C;
        tick();                                           // ISSUE
        tick();                                           // WAIT
        check("rw_busy_wait", busy_a[3], 32'd1);
        reset = 1'b0;
        tick();
        check("rw_busy_rst",   busy_a[3],     32'd0);
        check("rw_ram_en_rst", ram_en_a[3],   32'd0);
        tick();
        reset  = 1'b1;
        if_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rw_no_ack", if_ack_a[3], 32'd0);
        end
        check("rw_rdata_zero", if_rdata_a[3], 32'd0);
        access(3, 1'b0, 1'b0, 32'h0000_0014, 32'h0, cyc, nwe);
        check("rw_refetch_lat",   cyc,           32'd6);
        check("rw_refetch_rdata", if_rdata_a[3], 32'hCAFE_F00D);

        // ---- Alternation stress, LAT=2, both ports always requesting ----
        reset_pulse();
        if_addr = 32'h0000_000C;
        mem_addr = 32'h0000_0040; mem_we = 1'b0;
        if_req = 1'b1; mem_req = 1'b1;
        n_acks = 0; last_ack = 0; expect_data = 1'b1;
        for (int c = 1; c <= 120 && n_acks < 20; c++) begin
            tick();
            if (if_ack_a[1] || mem_ack_a[1]) begin
                check("alt_owner", mem_ack_a[1], {31'd0, expect_data});
                check("alt_both",  if_ack_a[1] & mem_ack_a[1], 32'd0);
                check("alt_gap",   c - last_ack, 32'd4);
                if (mem_ack_a[1]) check("alt_mem_rdata", mem_rdata_a[1], 32'h2222_2222);
                else              check("alt_if_rdata",  if_rdata_a[1],  32'h00A0_0093);
                last_ack    = c;
                expect_data = ~expect_data;
                n_acks++;
            end
            // Each requester drops in its ack cycle and re-raises next cycle.
            mem_req = ~mem_ack_a[1];
            if_req  = ~if_ack_a[1];
        end
        check("alt_count", n_acks, 32'd20);
        if_req  = 1'b0;
        mem_req = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_unified_mem_arbiter
`default_nettype wire
